uart_rx_engine: RTL
===================

// Module: uart_rx_engine
// PURPOSE
//  Parametrised UART receive engine: synchronises rx, detects and validates start bits, samples
//  5..MAX_DATA_BITS data bits LSB-first, plus optional parity and 1/2 stop bits. Completed frames
//  are buffered with per-frame parity/framing status in a show-ahead FIFO drained by a
//  valid/ready handshake. Sits between the rx pin and the UART CSR/DMA read path.
// PARAMETERS
//  MAX_DATA_BITS  9   widest supported data field; rx_data width
//  FIFO_DEPTH     8   receive FIFO entries, >=2, power of two
//  BAUD_WIDTH     32  width of baud_div (clk cycles per bit)
// PORTS
//  clk            in   1                  clock
//  rst_n          in   1                  asynchronous active-low reset
//  rx             in   1                  serial input, asynchronous, idle high
//  rx_en          in   1                  receiver enable
//  baud_div       in   BAUD_WIDTH         cycles per bit; values <4 treated as 4
//  data_bits      in   4                  data field length; clamped to [5, MAX_DATA_BITS]
//  parity_en      in   1                  parity bit present
//  odd_parity     in   1                  1 = odd, 0 = even parity
//  two_stop       in   1                  1 = two stop bits checked
//  overrun_clr    in   1                  clears sticky overrun
//  rx_ready       in   1                  consumer pops FIFO head
//  rx_valid       out  1                  FIFO not empty
//  rx_data        out  MAX_DATA_BITS      FIFO head data, right-aligned, upper bits 0
//  parity_error   out  1                  FIFO head parity status
//  framing_error  out  1                  FIFO head stop-bit status
//  overrun        out  1                  sticky: frame dropped because FIFO full
//  fifo_level     out  $clog2(FIFO_DEPTH+1)  occupied entries
// BEHAVIOUR
//  Reset: FSM IDLE, FIFO empty, all outputs 0. Config inputs are sampled at the start-bit edge
//   and held for the frame; changes mid-frame take effect on the next frame.
//  rx passes a 2-flop synchroniser (idle value 1 after reset) before any use.
//  Bit timer counts 0..baud_div-1; mid-bit point at count == baud_div>>1.
//  FSM: IDLE -> START on synchronised falling edge while rx_en=1.
//   START: mid-bit sample 1 -> false start, back to IDLE (nothing pushed); 0 -> DATA.
//   DATA: shift in data_bits samples LSB-first -> PARITY if parity_en, else STOP.
//   PARITY: sample bit; error = (XOR(data,bit) != odd_parity).
//   STOP: sample 1 or 2 stop bits; any 0 -> framing_error=1. At the last stop mid-bit, push
//    {framing, parity, data} and go to IDLE in the same cycle (ready for an immediate next start).
//  rx_en=0 in any state: FSM -> IDLE next cycle, partial frame discarded, FIFO untouched.
//  FIFO: rx_valid/rx_data/flags show the head combinationally; pop when rx_valid && rx_ready.
//   Push with FIFO full: frame dropped, overrun<=1, unless a pop occurs in the same cycle
//   (then the push is accepted and level is unchanged).
//   Pop on empty is ignored. Push+pop when not full/empty: level unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  overrun: set on drop; cleared by overrun_clr. Simultaneous set+clear -> stays 1.
//  Latency: rx_valid rises 1 cycle after the final stop mid-bit sample.
// CONFIGURATION
//  UART_RX_MAJORITY_VOTE_EN defined: every bit is sampled at mid-1, mid, mid+1; the bit value is
//   the 2-of-3 majority, decided at mid+1. Start bit is also validated by majority.
//  Not defined: a single sample at mid decides each bit; no extra pipeline cycle.
// TESTING
//  baud_div=16, 8N1, frame 0xA5 -> one entry rx_data=0x0A5, parity_error=0, framing_error=0, level=1.
//  8E1 0x03 with parity bit 1 -> parity_error=1; 8O1 0x03 with parity bit 1 -> parity_error=0.
//  7N2, second stop bit driven 0 -> framing_error=1, data 7 bits, bit[8:7]=0.
//  rx low for 6 cycles then high (baud_div=16) -> false start, no push, FSM back in IDLE.
//  FIFO_DEPTH+1 frames, rx_ready=0 -> level=FIFO_DEPTH, overrun=1, head = first frame;
//   overrun_clr -> 0.
//  MAJORITY_VOTE_EN: 1-cycle glitch at mid of a data bit -> bit value unchanged; without the
//   macro -> bit flips.

Source files
------------

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronised rx, start/data/parity/stop sampling, show-ahead status FIFO.
// Optional build macro UART_RX_MAJORITY_VOTE_EN selects 2-of-3 majority sampling of every bit.
module uart_rx_engine #(
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned BAUD_WIDTH    = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rx,
    input  logic                             rx_en,
    input  logic [BAUD_WIDTH-1:0]            baud_div,
    input  logic [3:0]                       data_bits,
    input  logic                             parity_en,
    input  logic                             odd_parity,
    input  logic                             two_stop,
    input  logic                             overrun_clr,
    input  logic                             rx_ready,
    output logic                             rx_valid,
    output logic [MAX_DATA_BITS-1:0]         rx_data,
    output logic                             parity_error,
    output logic                             framing_error,
    output logic                             overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
    localparam int unsigned DW = MAX_DATA_BITS;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW = DW + 2;
    localparam logic [3:0]            NB_MIN  = 4'd5;
    localparam logic [3:0]            NB_MAX  = 4'(MAX_DATA_BITS);
    localparam logic [BAUD_WIDTH-1:0] DIV_MIN = BAUD_WIDTH'(4);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic                  rx_s1_q, rx_s2_q, rx_prev_q;
    logic [BAUD_WIDTH-1:0] cnt_q, div_q, mid_c;
    logic [3:0]            nbits_q, bit_idx_q;
    logic                  par_en_q, odd_q, two_stop_q, stop_idx_q;
    logic [DW-1:0]         data_q;
    logic                  par_err_q, fr_err_q;
    logic                  fall_c, start_c, tick_c, bit_c, push_c;
    logic [BAUD_WIDTH-1:0] div_in_c;
    logic [3:0]            nb_in_c;
    logic [EW-1:0]         push_word_c;

    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q;
    logic                  full_c, pop_c, wr_ok_c, drop_c;

    // Two-flop synchroniser plus delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign fall_c   = rx_prev_q & ~rx_s2_q;
    assign start_c  = (state_q == IDLE) && rx_en && fall_c;
    assign mid_c    = div_q >> 1;
    assign div_in_c = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
    assign nb_in_c  = (data_bits < NB_MIN) ? NB_MIN :
                      (data_bits > NB_MAX) ? NB_MAX : data_bits;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic maj_a_q, maj_b_q;

    // Early samples at mid-1 and mid; the decision is taken at mid+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj_a_q <= 1'b1;
            maj_b_q <= 1'b1;
        end else begin
            if (cnt_q == mid_c - BAUD_WIDTH'(1)) maj_a_q <= rx_s2_q;
            if (cnt_q == mid_c)                  maj_b_q <= rx_s2_q;
        end
    end

    assign tick_c = (cnt_q == mid_c + BAUD_WIDTH'(1));
    assign bit_c  = (maj_a_q & maj_b_q) | (maj_a_q & rx_s2_q) | (maj_b_q & rx_s2_q);
`else
    assign tick_c = (cnt_q == mid_c);
    assign bit_c  = rx_s2_q;
`endif

    assign push_word_c = {fr_err_q | ~bit_c, par_err_q, data_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; the push happens at the final stop-bit decision.
    always_comb begin
        state_d = state_q;
        push_c  = 1'b0;
        if (!rx_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:   if (fall_c) state_d = START;
                START:  if (tick_c) state_d = bit_c ? IDLE : DATA;
                DATA:   if (tick_c && (bit_idx_q == nbits_q - 4'd1))
                            state_d = par_en_q ? PARITY : STOP;
                PARITY: if (tick_c) state_d = STOP;
                STOP:   if (tick_c && (stop_idx_q == two_stop_q)) begin
                            state_d = IDLE;
                            push_c  = 1'b1;
                        end
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame datapath: config captured at the start edge, bit timer starts at offset 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_q      <= DIV_MIN;
            nbits_q    <= NB_MIN;
            par_en_q   <= 1'b0;
            odd_q      <= 1'b0;
            two_stop_q <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            fr_err_q   <= 1'b0;
        end else if (start_c) begin
            cnt_q      <= BAUD_WIDTH'(1);
            div_q      <= div_in_c;
            nbits_q    <= nb_in_c;
            par_en_q   <= parity_en;
            odd_q      <= odd_parity;
            two_stop_q <= two_stop;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            fr_err_q   <= 1'b0;
        end else begin
            cnt_q <= (cnt_q >= div_q - BAUD_WIDTH'(1)) ? '0 : cnt_q + BAUD_WIDTH'(1);
            if (rx_en && tick_c) begin
                unique case (state_q)
                    DATA: begin
                        if (bit_c) data_q <= data_q | (DW'(1) << bit_idx_q);
                        bit_idx_q <= bit_idx_q + 4'd1;
                    end
                    PARITY: par_err_q <= ((^data_q) ^ bit_c) != odd_q;
                    STOP: begin
                        if (!bit_c) fr_err_q <= 1'b1;
                        stop_idx_q <= ~stop_idx_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign full_c  = (level_q == LW'(FIFO_DEPTH));
    assign pop_c   = (level_q != '0) && rx_ready;
    assign wr_ok_c = push_c && (!full_c || pop_c);
    assign drop_c  = push_c && full_c && !pop_c;

    // Receive FIFO with sticky overrun; a drop wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            overrun  <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                mem_q[wr_ptr_q] <= push_word_c;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({wr_ok_c, pop_c})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (drop_c)           overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

    assign rx_valid      = (level_q != '0);
    assign fifo_level    = level_q;
    assign rx_data       = mem_q[rd_ptr_q][DW-1:0];
    assign parity_error  = mem_q[rd_ptr_q][DW];
    assign framing_error = mem_q[rd_ptr_q][DW+1];

endmodule
